// File: rtl/clz_seq_ctrl.sv
// Purpose : 32-bit CLZ/CLO sequencer reusing one 16-bit leading-one encoder over two passes.
// Latency : 3 cycles from accept to done; 2 when CLZ_EARLY_EXIT_EN is defined and the upper half decides it.
// Backpres: busy high while computing; start is ignored while busy and must be held until busy drops.
//
// Optional feature macro: CLZ_EARLY_EXIT_EN (finish after the upper pass when it holds a set bit).
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled in IDLE or DONE
//   op_clo   0 = CLZ, 1 = CLO, sampled with start
//   operand  32-bit source value, sampled with start
//   cancel   pipeline flush, aborts any in-flight operation (wins over start)
//   busy     high in HI and LO
//   done     one-cycle pulse in DONE
//   result   zero-extended count 0..32, held until the next completed operation

// Purpose : 16-bit leading-one encoder; rd[4] = any bit set, rd[3:0] = index of highest set bit.
// Latency : combinational.
// Backpres: none.
module clz16 (
    input  logic [15:0] din,
    output logic [4:0]  rd
);
    always_comb begin
        rd = 5'd0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < 16; i++) begin
            if (din[i]) begin
                rd = {1'b1, i[3:0]};
            end
        end
    end
endmodule

module clz_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_clo,
    input  logic [31:0] operand,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] opr;
    logic [4:0]  acc;
    logic [5:0]  res;

    logic [15:0] enc_in;
    logic [4:0]  enc_rd;
    logic [4:0]  slice_cnt;
    logic [5:0]  lo_sum;

    // Single encoder, fed only through this half-select mux.
    assign enc_in = (state == S_LO) ? opr[15:0] : opr[31:16];

    clz16 u_clz16 (
        .din (enc_in),
        .rd  (enc_rd)
    );

    // Count of leading zeros within the current 16-bit slice: 15 - index, or 16 if empty.
    assign slice_cnt = enc_rd[4] ? {1'b0, ~enc_rd[3:0]} : 5'd16;
    assign lo_sum    = 6'd16 + {1'b0, slice_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            opr   <= 32'd0;
            acc   <= 5'd0;
            res   <= 6'd0;
        end else if (cancel) begin
            // Flush: abandon the operation without touching result.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // CLO is CLZ of the inverted operand.
                        opr   <= op_clo ? ~operand : operand;
                        state <= S_HI;
                    end
                end
                S_HI: begin
`ifdef CLZ_EARLY_EXIT_EN
                    if (enc_rd[4]) begin
                        res   <= {1'b0, slice_cnt};
                        state <= S_DONE;
                    end else begin
                        acc   <= slice_cnt;
                        state <= S_LO;
                    end
`else
                    acc   <= slice_cnt;
                    state <= S_LO;
`endif
                end
                S_LO: begin
                    // Only an all-zero upper half lets the lower half contribute.
                    res   <= (acc == 5'd16) ? lo_sum : {1'b0, acc};
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        opr   <= op_clo ? ~operand : operand;
                        state <= S_HI;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state == S_HI) || (state == S_LO);
    assign done   = (state == S_DONE);
    assign result = {26'd0, res};

endmodule

// File: doc/clz_seq_ctrl.md
# clz_seq_ctrl

Multi-cycle sequencer that computes 32-bit CLZ and CLO for the CPU's execute stage. It reuses a single existing 16-bit leading-one encoder (CLZ16) over two passes, upper half then lower half, instead of instantiating a 32-bit tree. It uses a start/busy/done handshake so the pipeline controller can stall the execute stage until the result is ready. It also accepts a flush-driven cancel.

## Interface
- No parameters; operand width fixed at 32, encoder slice fixed at 16.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when the unit can accept (see Operation).
- op_clo  in  1  0 = CLZ, 1 = CLO; sampled with start.
- operand  in  32  source register value; sampled with start.
- cancel  in  1  pipeline flush; aborts any in-flight operation.
- busy  out  1  high while the state is HI or LO.
- done  out  1  one-cycle pulse while the state is DONE.
- result  out  32  count, zero-extended 6-bit value in 0..32; held until overwritten.

## Operation
- The CLZ16 encoding is rd[4] = any bit set and rd[3:0] = index of the highest set bit.
  - Slice count = 16 when rd[4] = 0.
  - Slice count = ~rd[3:0] (that is, 15 − index) when rd[4] = 1.
- On accept, the unit latches opr = op_clo ? ~operand : operand. CLO is therefore computed as CLZ of the inverted operand.
- The encoder input is muxed: opr[31:16] in state HI, opr[15:0] in state LO. The mux is the only path to the encoder.
- States:
  - IDLE
    - Accept when start=1 and cancel=0.
    - On accept, go to HI.
  - HI
    - If the upper slice is nonzero and CLZ_EARLY_EXIT_EN is defined, write result = upper count and go to DONE.
    - Otherwise set acc = upper count and go to LO.
    - Without the macro, acc keeps the upper count even when that count is < 16.
  - LO
    - If acc = 16, result = 16 + lower count.
    - If acc < 16, result = acc.
    - Go to DONE.
  - DONE
    - done=1 and busy=0.
    - Accept a new start (back-to-back); on accept go to HI, otherwise go to IDLE.
- Arithmetic:
  - acc is 5 bits.
  - The sum is 6 bits; its maximum is 32 (operand 0 for CLZ, 0xFFFFFFFF for CLO).
  - result[31:6] is always 0.
- cancel=1 in any state forces IDLE at the next edge.
  - result is not written and no done pulse follows.
  - cancel together with start: cancel wins and start is ignored.
- start while busy=1 is ignored; the controller must hold start until busy is low.
- Asynchronous reset forces IDLE, busy=0, done=0, result=0, acc=0 and opr=0, including during an operation. Any in-flight operation is discarded.

## Timing
- Cycle 0: start is accepted.
- Cycle 1: state HI, busy=1.
- Early exit: done=1 and result valid in cycle 2.
- Full path: state LO in cycle 2, done=1 and result valid in cycle 3.
- result changes only on the edge that enters DONE.
- Back-to-back: with start held high, a new operation is accepted in the DONE cycle. Throughput is one operation per 2 or 3 cycles.
- busy and done are registered, decoded directly from the state register; there is no combinational path from inputs to outputs.
- The critical path is the encoder plus a 5-bit add; it must fit within one execute-stage cycle.

## Configuration
- Macro: CLZ_EARLY_EXIT_EN.
- Defined: HI terminates when the upper half contains a set bit (a 0 bit for CLO). Latency is 2 cycles in that case and 3 cycles otherwise.
- Undefined: LO is always visited, giving a fixed 3-cycle latency. This simplifies hazard scheduling in the pipeline controller.
- The result value is identical in both builds.

## Test plan
- CLZ 0x00010000 -> result=15; done in cycle 2 with the macro, cycle 3 without.
- CLZ 0x00000000 -> result=32, done in cycle 3; CLO 0xFFFFFFFF -> result=32.
- CLZ 0x0000FFFF -> result=16; CLO 0xFFFF0000 -> result=16; CLZ 0x80000000 -> result=0.
- Start with 0x00000001 and assert cancel in cycle 1 -> no done pulse, result keeps its previous value, unit is IDLE in cycle 2.
- Drop rst_n during LO -> busy, done and result go to 0 immediately. Start after release -> correct result.
- Hold start high with operands 0x00F00000 then 0x00000003:
  - results are 8 then 30;
  - the second operation is accepted in the first operation's DONE cycle;
  - start pulses while busy are ignored.
